// File: rtl/cache_arbiter_types.sv
// -----------------------------------------------------------------------------
// cache_arbiter_types
// Shared types and constants for the I/D cache arbiter and its line/burst
// adapter: controller state encoding, requester select, and beat geometry.
// -----------------------------------------------------------------------------
package cache_arbiter_types;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Which cache owns (or last owned) the memory port.
  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } req_sel_t;

  // Beats per cache line and the width of the beat counter.
  localparam int NBEATS = 4;
  localparam int BEAT_W = $clog2(NBEATS);

  // Byte-offset bits inside a line; forced to zero on the memory address.
  localparam int OFFSET_W = 5;

endpackage

// File: rtl/line_burst_adapter.sv
// -----------------------------------------------------------------------------
// line_burst_adapter
// Converts between a full cache line and a sequence of NBEATS memory beats.
// Holds the line buffer and the beat counter for the transaction in flight.
//
// Ports
//   clk         clock
//   rst         synchronous reset, active low
//   load        start of a transaction: clear beat counter, capture load_line
//   load_line   line to be written (ignored content for reads)
//   active      controller is in the burst phase
//   is_write    current transaction is a write
//   beat_ack    memory acknowledged the current beat
//   beat_rdata  read data of the current beat
//   beat_wdata  write data for the current beat (slice of the buffered line)
//   last_beat   acknowledged beat is the final one of the line
//   line_next   buffered line with the current read beat merged in
// -----------------------------------------------------------------------------
module line_burst_adapter
  import cache_arbiter_types::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [LINE_W-1:0]  load_line,
  input  logic               active,
  input  logic               is_write,
  input  logic               beat_ack,
  input  logic [BURST_W-1:0] beat_rdata,
  output logic [BURST_W-1:0] beat_wdata,
  output logic               last_beat,
  output logic [LINE_W-1:0]  line_next
);

  logic [BEAT_W-1:0] beat_q;
  logic [LINE_W-1:0] line_q;

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples its inputs as they were before this clock edge.
  // NOTE: the line buffer is an ordinary register, not a RAM, so it is cleared
  // on reset like the rest of the state; nothing stale survives a reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_q <= '0;
      line_q <= '0;
    end else if (load) begin
      beat_q <= '0;
      line_q <= load_line;
    end else if (active && beat_ack) begin
      beat_q <= beat_q + BEAT_W'(1);
      if (!is_write) begin
        line_q <= line_next;
      end
    end
  end

  // NOTE: the combinational output gets a full default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    line_next = line_q;
    line_next[beat_q*BURST_W +: BURST_W] = beat_rdata;
  end

  assign beat_wdata = line_q[beat_q*BURST_W +: BURST_W];
  assign last_beat  = active && beat_ack && (beat_q == BEAT_W'(NBEATS - 1));

endmodule

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
// Shares one burst-oriented memory port between an I-cache and a D-cache.
// One line transaction at a time; ties are broken round-robin, with D winning
// the first tie after reset.
//
// Ports
//   clk, rst                       clock, synchronous active-low reset
//   i_read/i_write/i_addr/i_wdata  I-cache line request
//   i_rdata/i_resp                 I-cache read line / completion pulse
//   d_*                            same set for the D-cache
//   pmem_read/pmem_write           memory command, held for the whole burst
//   pmem_address                   line-aligned memory address
//   pmem_wdata/pmem_rdata          beat data to/from memory
//   pmem_resp                      per-beat acknowledge from memory
// -----------------------------------------------------------------------------
module cache_arbiter
  import cache_arbiter_types::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_read,
  input  logic               i_write,
  input  logic [31:0]        i_addr,
  input  logic [LINE_W-1:0]  i_wdata,
  output logic [LINE_W-1:0]  i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [31:0]        d_addr,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               d_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [31:0]        pmem_address,
  output logic [BURST_W-1:0] pmem_wdata,
  input  logic [BURST_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);

  arb_state_t state_q, state_d;
  req_sel_t   winner_q, last_q, grant;
  logic       write_q;
  logic [31:OFFSET_W] line_addr_q;
  logic [LINE_W-1:0]  i_rdata_q, d_rdata_q;

  logic               i_req, d_req, start, busy, last_beat;
  logic [LINE_W-1:0]  grant_wdata, line_next;
  logic [BURST_W-1:0] beat_wdata;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;
  assign start = (state_q == IDLE) && (i_req || d_req);
  assign busy  = (state_q == BUSY);

  // On a tie, grant whichever cache did not get the previous grant.
  always_comb begin
    grant = SEL_I;
    if (i_req && d_req) begin
      grant = (last_q == SEL_I) ? SEL_D : SEL_I;
    end else if (d_req) begin
      grant = SEL_D;
    end
  end

  assign grant_wdata = (grant == SEL_D) ? d_wdata : i_wdata;

  line_burst_adapter #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W)
  ) u_adapter (
    .clk        (clk),
    .rst        (rst),
    .load       (start),
    .load_line  (grant_wdata),
    .active     (busy),
    .is_write   (write_q),
    .beat_ack   (pmem_resp),
    .beat_rdata (pmem_rdata),
    .beat_wdata (beat_wdata),
    .last_beat  (last_beat),
    .line_next  (line_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. Requests arriving in DONE are not looked at.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_req || d_req) state_d = BUSY;
      BUSY:    if (last_beat)      state_d = DONE;
      DONE:                        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Transaction context and returned lines. A cache asserting both read and
  // write is treated as writing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      winner_q    <= SEL_I;
      last_q      <= SEL_I;
      write_q     <= 1'b0;
      line_addr_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (start) begin
        winner_q    <= grant;
        last_q      <= grant;
        write_q     <= (grant == SEL_D) ? d_write : i_write;
        line_addr_q <= (grant == SEL_D) ? d_addr[31:OFFSET_W] : i_addr[31:OFFSET_W];
      end
      // Capture the final beat together with the line so rdata is valid in DONE.
      if (last_beat && !write_q) begin
        if (winner_q == SEL_D) d_rdata_q <= line_next;
        else                   i_rdata_q <= line_next;
      end
    end
  end

  // Output logic.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state_q)
      BUSY: begin
        pmem_read    = !write_q;
        pmem_write   = write_q;
        pmem_address = {line_addr_q, {OFFSET_W{1'b0}}};
        pmem_wdata   = write_q ? beat_wdata : '0;
      end
      DONE: begin
        i_resp = (winner_q == SEL_I);
        d_resp = (winner_q == SEL_D);
      end
      default: ;
    endcase
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
// Directed and randomized stimulus for cache_arbiter. The bench plays the
// memory and both caches; expectations come from a transaction-level model
// (pending flags per cache, round-robin tie rule, line = beats in order).
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = LW / BW;

  logic          clk;
  logic          rst;
  logic          i_read, i_write, d_read, d_write;
  logic [31:0]   i_addr, d_addr;
  logic [LW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_resp, d_resp;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [31:0]   pmem_address;
  logic [BW-1:0] pmem_wdata, pmem_rdata;

  cache_arbiter #(.LINE_W(LW), .BURST_W(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit            i_pend, d_pend, i_wr_m, d_wr_m, last_d;
  logic [31:0]   i_addr_m, d_addr_m;
  logic [LW-1:0] i_wl_m, d_wl_m, i_rl_m, d_rl_m;
  logic [LW-1:0] exp_i_rd, exp_d_rd;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // Raise a request from one cache and record it in the model.
  task automatic issue(input bit to_d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [LW-1:0] wl, input logic [LW-1:0] rl);
    if (to_d) begin
      d_read = rd; d_write = wr; d_addr = a; d_wdata = wl;
      d_pend = 1'b1; d_wr_m = wr; d_addr_m = a; d_wl_m = wl; d_rl_m = rl;
    end else begin
      i_read = rd; i_write = wr; i_addr = a; i_wdata = wl;
      i_pend = 1'b1; i_wr_m = wr; i_addr_m = a; i_wl_m = wl; i_rl_m = rl;
    end
  endtask

  // Play memory for one granted line transaction. Entered at a negedge in
  // IDLE with requests already driven; leaves at a negedge back in IDLE.
  task automatic do_txn(input bit win_d, input bit wr, input logic [31:0] addr,
                        input logic [LW-1:0] wl, input logic [LW-1:0] rl, input int gap);
    int beats, waited, cyc;
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFE0;
    beats = 0; waited = 0; cyc = 0;
    while (beats < NB && cyc < 200) begin
      @(negedge clk);
      cyc++;
      check("busy_pmem_read", pmem_read, !wr);
      check("busy_pmem_write", pmem_write, wr);
      check("busy_pmem_address", pmem_address, exp_addr);
      if (wr) check("busy_pmem_wdata", pmem_wdata, wl[beats*BW +: BW]);
      check("busy_resp_quiet", {i_resp, d_resp}, 2'b00);
      if (waited == gap) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rl[beats*BW +: BW];
        beats++;
        waited = 0;
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = {$urandom, $urandom};
        waited++;
      end
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    if (!wr) begin
      if (win_d) exp_d_rd = rl;
      else       exp_i_rd = rl;
    end
    check("done_pmem_read", pmem_read, 1'b0);
    check("done_pmem_write", pmem_write, 1'b0);
    check("done_i_resp", i_resp, !win_d);
    check("done_d_resp", d_resp, win_d);
    check("done_i_rdata", i_rdata, exp_i_rd);
    check("done_d_rdata", d_rdata, exp_d_rd);
    if (win_d) begin d_read = 1'b0; d_write = 1'b0; end
    else       begin i_read = 1'b0; i_write = 1'b0; end
    @(negedge clk);
    check("after_resp_quiet", {i_resp, d_resp}, 2'b00);
    check("after_cmd_quiet", {pmem_read, pmem_write}, 2'b00);
  endtask

  // Model: serve the next pending request by the arbitration rules.
  task automatic serve(input int gap);
    bit wd;
    if (i_pend && d_pend) wd = !last_d;
    else                  wd = d_pend;
    if (wd) do_txn(1'b1, d_wr_m, d_addr_m, d_wl_m, d_rl_m, gap);
    else    do_txn(1'b0, i_wr_m, i_addr_m, i_wl_m, i_rl_m, gap);
    last_d = wd;
    if (wd) d_pend = 1'b0;
    else    i_pend = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LW-1:0] l0, l1, wline, rline;

    rst = 1'b0;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
    i_pend = 0; d_pend = 0; last_d = 0;
    exp_i_rd = '0; exp_d_rd = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_pmem_cmd", {pmem_read, pmem_write}, 2'b00);
    check("rst_pmem_address", pmem_address, 32'h0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_resp", {i_resp, d_resp}, 2'b00);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous reads after reset: D first, then I.
    l0 = rand_line(); l1 = rand_line();
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0200, '0, l0);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0300, '0, l1);
    serve(0);
    serve(0);

    // I-read of a known line from an unaligned address.
    rline = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0064, '0, rline);
    serve(0);

    // D-write of four distinct beats.
    wline = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
             64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    issue(1'b1, 1'b0, 1'b1, 32'h0000_1000, wline, '0);
    serve(0);

    // Second tie: D was granted last, so I goes first.
    issue(1'b0, 1'b1, 1'b0, 32'h0000_4440, '0, rand_line());
    issue(1'b1, 1'b1, 1'b0, 32'h0000_5550, '0, rand_line());
    serve(1);
    serve(1);

    // Slow memory: three idle cycles before every beat.
    issue(1'b1, 1'b1, 1'b0, 32'h0000_7788, '0, rand_line());
    serve(3);

    // Stray acknowledges while idle change nothing.
    for (int k = 0; k < 3; k++) begin
      pmem_resp = 1'b1;
      pmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      check("stray_pmem_cmd", {pmem_read, pmem_write}, 2'b00);
      check("stray_resp", {i_resp, d_resp}, 2'b00);
    end
    pmem_resp = 1'b0;

    // Read and write together from one cache is a write.
    issue(1'b1, 1'b1, 1'b1, 32'h0000_9a00, rand_line(), rand_line());
    serve(0);

    // Reset after the second beat of a D-read aborts it.
    issue(1'b1, 1'b1, 1'b0, 32'h0000_2020, '0, rand_line());
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("abort_busy_read", pmem_read, 1'b1);
      pmem_resp = 1'b1;
      pmem_rdata = {$urandom, $urandom};
    end
    @(negedge clk);
    check("abort_still_busy", pmem_read, 1'b1);
    pmem_resp = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abort_pmem_read", pmem_read, 1'b0);
    check("abort_d_resp", d_resp, 1'b0);
    check("abort_d_rdata", d_rdata, '0);
    check("abort_i_rdata", i_rdata, '0);
    rst = 1'b1;
    last_d = 1'b0;
    exp_i_rd = '0;
    exp_d_rd = '0;
    serve(0);

    // Random request mixes, served by the model's arbitration rules.
    for (int k = 0; k < 16; k++) begin
      int pat;
      int m;
      pat = $urandom_range(1, 3);
      if (pat[0]) begin
        m = $urandom_range(0, 2);
        issue(1'b0, m != 1, m != 0, $urandom, rand_line(), rand_line());
      end
      if (pat[1]) begin
        m = $urandom_range(0, 2);
        issue(1'b1, m != 1, m != 0, $urandom, rand_line(), rand_line());
      end
      while (i_pend || d_pend) serve($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
